// File: rtl/pin_lockout_ctrl.sv
// PIN-entry supervisor: checks entered PINs, counts failures, drives the lockout timer.
// Define LOCK_RETAIN_EN to keep the lockout running after card removal.
`timescale 1ns/1ps
module pin_lockout_ctrl #(
   parameter int MAX_TRIES = 3,
   parameter int PIN_W     = 16,
   parameter int TRY_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             card_in,
   input  logic             pin_valid,
   input  logic [PIN_W-1:0] pin_in,
   input  logic [PIN_W-1:0] stored_pin,
   input  logic             time_up,
   output logic             start_timer,
   output logic             locked,
   output logic             access_granted,
   output logic             pin_ok,
   output logic             pin_fail,
   output logic [TRY_W-1:0] attempts_left
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PIN,
      CHECK,
      GRANTED,
      LOCKED
   } state_t;

   localparam logic [TRY_W-1:0] MAX_C = TRY_W'(MAX_TRIES);

   state_t           state, state_n;
   logic [TRY_W-1:0] cnt, cnt_n;
   logic [PIN_W-1:0] pin_q, pin_q_n;
   logic             lock_arm;
   logic             ok_n, fail_n;
   logic             abort;

`ifdef LOCK_RETAIN_EN
   assign abort = 1'b0;
`else
   assign abort = ~card_in;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pin_q_n = pin_q;
      ok_n    = 1'b0;
      fail_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (card_in) state_n = WAIT_PIN;
         end
         WAIT_PIN: begin
            if (!card_in) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (pin_valid) begin
               pin_q_n = pin_in;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (pin_q == stored_pin) begin
               state_n = GRANTED;
               ok_n    = 1'b1;
               cnt_n   = '0;
            end else begin
               fail_n = 1'b1;
               cnt_n  = cnt + 1'b1;
               if (cnt_n == MAX_C) state_n = LOCKED;
               else                state_n = WAIT_PIN;
            end
         end
         GRANTED: begin
            if (!card_in) state_n = IDLE;
         end
         LOCKED: begin
            // lock_arm is low in the first cycle, masking a stale time_up
            if (abort || (lock_arm && time_up)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         pin_q          <= '0;
         lock_arm       <= 1'b0;
         start_timer    <= 1'b0;
         locked         <= 1'b0;
         access_granted <= 1'b0;
         pin_ok         <= 1'b0;
         pin_fail       <= 1'b0;
         attempts_left  <= MAX_C;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         pin_q          <= pin_q_n;
         lock_arm       <= (state == LOCKED) && (state_n == LOCKED);
         start_timer    <= (state_n == LOCKED);
         locked         <= (state_n == LOCKED);
         access_granted <= (state_n == GRANTED);
         pin_ok         <= ok_n;
         pin_fail       <= fail_n;
         attempts_left  <= MAX_C - cnt_n;
      end
   end

endmodule

// File: tb/tb_pin_lockout_ctrl.sv
// Randomised bench for pin_lockout_ctrl against a behavioural session model,
// plus directed sequences with literal expectations.
`timescale 1ns/1ps
module tb_pin_lockout_ctrl;

   localparam int MAX = 3;
`ifdef LOCK_RETAIN_EN
   localparam bit RETAIN = 1'b1;
`else
   localparam bit RETAIN = 1'b0;
`endif

   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_CHECK = 2;
   localparam int P_OPEN  = 3;
   localparam int P_LOCK  = 4;

   logic        clk;
   logic        rst;
   logic        card_in;
   logic        pin_valid;
   logic [15:0] pin_in;
   logic [15:0] stored_pin;
   logic        time_up;
   logic        start_timer;
   logic        locked;
   logic        access_granted;
   logic        pin_ok;
   logic        pin_fail;
   logic [2:0]  attempts_left;

   int nvec = 0;
   int nbad = 0;

   int          m_mode  = P_IDLE;
   int          m_fails = 0;
   logic [15:0] m_held  = '0;
   int          m_age   = 0;
   bit          m_ok    = 1'b0;
   bit          m_fail  = 1'b0;

   pin_lockout_ctrl #(.MAX_TRIES(MAX), .PIN_W(16), .TRY_W(3)) dut (
      .clk(clk),
      .rst(rst),
      .card_in(card_in),
      .pin_valid(pin_valid),
      .pin_in(pin_in),
      .stored_pin(stored_pin),
      .time_up(time_up),
      .start_timer(start_timer),
      .locked(locked),
      .access_granted(access_granted),
      .pin_ok(pin_ok),
      .pin_fail(pin_fail),
      .attempts_left(attempts_left)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nbad++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Session model: one step per sampled clock edge
   task automatic model_step();
      int          md  = m_mode;
      int          f   = m_fails;
      logic [15:0] h   = m_held;
      int          age = m_age;
      bit          ok  = 1'b0;
      bit          fl  = 1'b0;
      if (md == P_IDLE) begin
         if (card_in) md = P_WAIT;
      end else if (md == P_WAIT) begin
         if (!card_in) begin
            md = P_IDLE;
            f  = 0;
         end else if (pin_valid) begin
            h  = pin_in;
            md = P_CHECK;
         end
      end else if (md == P_CHECK) begin
         if (h == stored_pin) begin
            md = P_OPEN;
            ok = 1'b1;
            f  = 0;
         end else begin
            fl  = 1'b1;
            f   = f + 1;
            md  = (f >= MAX) ? P_LOCK : P_WAIT;
            age = 0;
         end
      end else if (md == P_OPEN) begin
         if (!card_in) md = P_IDLE;
      end else begin
         if ((!RETAIN && !card_in) || (age >= 1 && time_up)) begin
            md = P_IDLE;
            f  = 0;
         end
         age = age + 1;
      end
      m_mode  <= md;
      m_fails <= f;
      m_held  <= h;
      m_age   <= age;
      m_ok    <= ok;
      m_fail  <= fl;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode  <= P_IDLE;
         m_fails <= 0;
         m_held  <= '0;
         m_age   <= 0;
         m_ok    <= 1'b0;
         m_fail  <= 1'b0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      check("start_timer", int'(start_timer), int'(m_mode == P_LOCK));
      check("locked", int'(locked), int'(m_mode == P_LOCK));
      check("access_granted", int'(access_granted), int'(m_mode == P_OPEN));
      check("pin_ok", int'(pin_ok), int'(m_ok));
      check("pin_fail", int'(pin_fail), int'(m_fail));
      check("attempts_left", int'(attempts_left), MAX - m_fails);
   end

   task automatic apply(input logic c, input logic v,
                        input logic [15:0] p, input logic t);
      card_in   = c;
      pin_valid = v;
      pin_in    = p;
      time_up   = t;
      @(negedge clk);
      #1;
   endtask

   task automatic lockout();
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         apply(1'b1, 1'b1, 16'h0BAD, 1'b0);
         apply(1'b1, 1'b0, 16'h0, 1'b0);
      end
   endtask

   initial begin
      logic        c;
      logic        v;
      logic        t;
      logic [15:0] p;
      rst        = 1'b0;
      card_in    = 1'b0;
      pin_valid  = 1'b0;
      pin_in     = '0;
      stored_pin = 16'h1234;
      time_up    = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      #1;
      check("rst_attempts", int'(attempts_left), 3);
      check("rst_locked", int'(locked), 0);
      check("rst_granted", int'(access_granted), 0);
      rst = 1'b0;

      // correct PIN
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      apply(1'b1, 1'b1, 16'h1234, 1'b0);
      check("ok_latency0", int'(pin_ok), 0);
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      check("ok_pulse", int'(pin_ok), 1);
      check("ok_granted", int'(access_granted), 1);
      check("ok_attempts", int'(attempts_left), 3);
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      check("ok_one_cycle", int'(pin_ok), 0);
      apply(1'b0, 1'b0, 16'h0, 1'b0);
      check("card_out_granted", int'(access_granted), 0);

      // two wrong then right
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      apply(1'b1, 1'b1, 16'h1111, 1'b0);
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      check("w1_fail", int'(pin_fail), 1);
      check("w1_attempts", int'(attempts_left), 2);
      apply(1'b1, 1'b1, 16'h2222, 1'b0);
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      check("w2_attempts", int'(attempts_left), 1);
      apply(1'b1, 1'b1, 16'h1234, 1'b0);
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      check("w3_ok", int'(pin_ok), 1);
      check("w3_attempts", int'(attempts_left), 3);
      apply(1'b0, 1'b0, 16'h0, 1'b0);

      // lockout, stale time_up masked, then release
      lockout();
      check("lk_fail", int'(pin_fail), 1);
      check("lk_locked", int'(locked), 1);
      check("lk_timer", int'(start_timer), 1);
      check("lk_attempts", int'(attempts_left), 0);
      apply(1'b1, 1'b1, 16'h1234, 1'b1);
      check("lk_mask", int'(locked), 1);
      check("lk_no_ok", int'(pin_ok), 0);
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      check("lk_release", int'(start_timer), 0);
      check("lk_rel_att", int'(attempts_left), 3);

      // time_up outside LOCKED
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      apply(1'b1, 1'b0, 16'h0, 1'b1);
      check("tu_wait", int'(locked), 0);
      apply(1'b0, 1'b0, 16'h0, 1'b0);

      // card removed during lockout
      lockout();
      apply(1'b0, 1'b0, 16'h0, 1'b0);
      check("rm_locked", int'(locked), RETAIN ? 1 : 0);
      apply(1'b0, 1'b0, 16'h0, 1'b1);
      check("rm_done", int'(start_timer), 0);

      // asynchronous reset mid-lockout
      lockout();
      #2 rst = 1'b1;
      #1;
      check("ar_timer", int'(start_timer), 0);
      check("ar_fail", int'(pin_fail), 0);
      check("ar_attempts", int'(attempts_left), 3);
      apply(1'b0, 1'b0, 16'h0, 1'b0);
      rst = 1'b0;

      // random sessions
      for (int i = 0; i < 4000; i++) begin
         c = card_in;
         if ($urandom_range(0, 15) == 0) c = ~c;
         if (!c && $urandom_range(0, 3) == 0) stored_pin = 16'($urandom);
         v = ($urandom_range(0, 3) == 0);
         p = ($urandom_range(0, 2) == 0) ? stored_pin : 16'($urandom);
         t = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            apply(c, v, p, t);
            rst = 1'b0;
         end else begin
            apply(c, v, p, t);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
